// File: rtl/sram_access_arbiter.sv
// Round-robin arbiter sharing one sample memory between play/record/mix/loaddata engines.
// Optional macro PLAY_PRIORITY_EN: requester 0 (play) wins every arbitration it takes part in.
module sram_access_arbiter #(
  parameter int unsigned NUM_REQ       = 4,
  parameter int unsigned ADDR_W        = 23,
  parameter int unsigned DATA_W        = 16,
  parameter int unsigned ACCESS_CYCLES = 2
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ-1:0]         req_we,
  input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]  req_wdata,
  output logic [NUM_REQ-1:0]         ack,
  output logic [DATA_W-1:0]          rdata,
  output logic                       busy,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [DATA_W-1:0]          mem_wdata,
  input  logic [DATA_W-1:0]          mem_rdata,
  output logic                       mem_ce,
  output logic                       mem_we
);

  localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CntW = $clog2(ACCESS_CYCLES + 1);

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StDone
  } state_e;

  state_e              state_q;
  logic [IdxW-1:0]     last_grant_q;
  logic [IdxW-1:0]     winner_q;
  logic [CntW-1:0]     cnt_q;
  logic [NUM_REQ-1:0]  ack_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                busy_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q;
  logic                mem_ce_q;
  logic                mem_we_q;

  logic [NUM_REQ-1:0]  rr_req;
  logic [IdxW-1:0]     cand;
  logic                rr_found;
  logic [IdxW-1:0]     rr_idx;
  logic                grant_valid;
  logic [IdxW-1:0]     grant_idx;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;
  logic                sel_we;

  // Search upward from last_grant+1, wrapping, so the previous winner is considered last.
  always_comb begin
    rr_req = req;
`ifdef PLAY_PRIORITY_EN
    rr_req[0] = 1'b0;
`endif
    cand     = '0;
    rr_found = 1'b0;
    rr_idx   = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand = IdxW'((32'(last_grant_q) + i) % NUM_REQ);
      if (!rr_found && rr_req[cand]) begin
        rr_found = 1'b1;
        rr_idx   = cand;
      end
    end
  end

  always_comb begin
`ifdef PLAY_PRIORITY_EN
    grant_valid = req[0] | rr_found;
    grant_idx   = req[0] ? '0 : rr_idx;
`else
    grant_valid = rr_found;
    grant_idx   = rr_idx;
`endif
    sel_addr  = req_addr[32'(grant_idx)*ADDR_W +: ADDR_W];
    sel_wdata = req_wdata[32'(grant_idx)*DATA_W +: DATA_W];
    sel_we    = req_we[grant_idx];
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q      <= StIdle;
      last_grant_q <= IdxW'(NUM_REQ - 1);
      winner_q     <= '0;
      cnt_q        <= '0;
      ack_q        <= '0;
      rdata_q      <= '0;
      busy_q       <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_ce_q     <= 1'b0;
      mem_we_q     <= 1'b0;
    end else begin
      ack_q <= '0;
      case (state_q)
        StIdle: begin
          if (grant_valid) begin
            winner_q    <= grant_idx;
            mem_addr_q  <= sel_addr;
            mem_wdata_q <= sel_wdata;
            mem_we_q    <= sel_we;
            mem_ce_q    <= 1'b1;
            busy_q      <= 1'b1;
            cnt_q       <= CntW'(ACCESS_CYCLES);
            state_q     <= StAccess;
          end
        end
        StAccess: begin
          cnt_q <= cnt_q - CntW'(1);
          if (cnt_q == CntW'(1)) begin
            // mem_we_q still holds the latched direction on this last ACCESS cycle
            if (!mem_we_q) begin
              rdata_q <= mem_rdata;
            end
            ack_q[winner_q] <= 1'b1;
            mem_ce_q        <= 1'b0;
            mem_we_q        <= 1'b0;
            state_q         <= StDone;
          end
        end
        StDone: begin
          last_grant_q <= winner_q;
          busy_q       <= 1'b0;
          state_q      <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign ack       = ack_q;
  assign rdata     = rdata_q;
  assign busy      = busy_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_ce    = mem_ce_q;
  assign mem_we    = mem_we_q;

endmodule

// File: tb/tb_sram_access_arbiter.sv
// Directed testbench for sram_access_arbiter with hand-computed expectations.
// Define PLAY_PRIORITY_EN for both RTL and bench to exercise the play-priority build.
module tb_sram_access_arbiter;

  localparam int NR = 4;
  localparam int AW = 23;
  localparam int DW = 16;

  logic              i_clk;
  logic              i_rst;
  logic [NR-1:0]     req;
  logic [NR-1:0]     req_we;
  logic [NR*AW-1:0]  req_addr;
  logic [NR*DW-1:0]  req_wdata;
  logic [NR-1:0]     ack;
  logic [DW-1:0]     rdata;
  logic              busy;
  logic [AW-1:0]     mem_addr;
  logic [DW-1:0]     mem_wdata;
  logic [DW-1:0]     mem_rdata;
  logic              mem_ce;
  logic              mem_we;

  int n_pass;
  int n_total;

  sram_access_arbiter #(
    .NUM_REQ      (NR),
    .ADDR_W       (AW),
    .DATA_W       (DW),
    .ACCESS_CYCLES(2)
  ) dut (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .req      (req),
    .req_we   (req_we),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .ack      (ack),
    .rdata    (rdata),
    .busy     (busy),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ce   (mem_ce),
    .mem_we   (mem_we)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Waits for the next ack; gap = cycles waited, or -1 on timeout.
  task automatic wait_any_ack(output logic [NR-1:0] seen, output int gap);
    gap  = 0;
    seen = '0;
    while (gap < 20) begin
      tick();
      gap++;
      if (ack !== '0) begin
        seen = ack;
        return;
      end
    end
    gap = -1;
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
  endtask

  task automatic test_reset();
    req       = '0;
    req_we    = '0;
    req_addr  = '0;
    req_wdata = '0;
    mem_rdata = '0;
    i_rst     = 1'b1;
    tick();
    n_total++; if (ack !== 4'b0000) $display("FAIL reset_ack got %b exp 0000", ack); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy); else n_pass++;
    n_total++; if (mem_ce !== 1'b0) $display("FAIL reset_ce got %b exp 0", mem_ce); else n_pass++;
    n_total++; if (mem_we !== 1'b0) $display("FAIL reset_we got %b exp 0", mem_we); else n_pass++;
    n_total++; if (rdata !== 16'h0) $display("FAIL reset_rdata got %h exp 0000", rdata); else n_pass++;
    n_total++; if (mem_addr !== 23'h0) $display("FAIL reset_addr got %h exp 0", mem_addr); else n_pass++;
    n_total++; if (mem_wdata !== 16'h0) $display("FAIL reset_wdata got %h exp 0", mem_wdata);
    else n_pass++;
    i_rst = 1'b0;
    tick();
    n_total++; if (busy !== 1'b0) $display("FAIL idle_busy got %b exp 0", busy); else n_pass++;
  endtask

  task automatic test_single_read();
    mem_rdata          = 16'hBEEF;
    req_addr[1*AW +: AW] = 23'h000123;
    req_we[1]          = 1'b0;
    req                = 4'b0010;
    for (int c = 0; c < 2; c++) begin
      tick();
      n_total++; if (mem_ce !== 1'b1) $display("FAIL rd_ce c%0d got %b exp 1", c, mem_ce);
      else n_pass++;
      n_total++; if (mem_addr !== 23'h000123) $display("FAIL rd_addr c%0d got %h exp 000123", c,
                                                       mem_addr); else n_pass++;
      n_total++; if (mem_we !== 1'b0) $display("FAIL rd_we c%0d got %b exp 0", c, mem_we);
      else n_pass++;
      n_total++; if (ack !== 4'b0000) $display("FAIL rd_early_ack c%0d got %b exp 0000", c, ack);
      else n_pass++;
    end
    tick();
    n_total++; if (ack !== 4'b0010) $display("FAIL rd_ack got %b exp 0010", ack); else n_pass++;
    n_total++; if (rdata !== 16'hBEEF) $display("FAIL rd_data got %h exp beef", rdata); else n_pass++;
    n_total++; if (mem_ce !== 1'b0) $display("FAIL rd_done_ce got %b exp 0", mem_ce); else n_pass++;
    req = '0;
    tick();
    n_total++; if (ack !== 4'b0000) $display("FAIL rd_ack_len got %b exp 0000", ack); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL rd_idle_busy got %b exp 0", busy); else n_pass++;
    n_total++; if (rdata !== 16'hBEEF) $display("FAIL rd_hold got %h exp beef", rdata); else n_pass++;
  endtask

  task automatic test_single_write();
    mem_rdata             = 16'h5555;
    req_addr[3*AW +: AW]  = 23'h7FFFFF;
    req_wdata[3*DW +: DW] = 16'h1234;
    req_we[3]             = 1'b1;
    req                   = 4'b1000;
    for (int c = 0; c < 2; c++) begin
      tick();
      n_total++; if (mem_we !== 1'b1 || mem_ce !== 1'b1)
        $display("FAIL wr_we_ce c%0d got %b%b exp 11", c, mem_we, mem_ce); else n_pass++;
      n_total++; if (mem_wdata !== 16'h1234) $display("FAIL wr_wdata c%0d got %h exp 1234", c,
                                                      mem_wdata); else n_pass++;
      n_total++; if (mem_addr !== 23'h7FFFFF) $display("FAIL wr_addr c%0d got %h exp 7fffff", c,
                                                       mem_addr); else n_pass++;
    end
    tick();
    n_total++; if (ack !== 4'b1000) $display("FAIL wr_ack got %b exp 1000", ack); else n_pass++;
    n_total++; if (mem_we !== 1'b0) $display("FAIL wr_done_we got %b exp 0", mem_we); else n_pass++;
    n_total++; if (rdata !== 16'hBEEF) $display("FAIL wr_rdata got %h exp beef", rdata); else n_pass++;
    req    = '0;
    req_we = '0;
    tick();
    n_total++; if (ack !== 4'b0000) $display("FAIL wr_ack_len got %b exp 0000", ack); else n_pass++;
  endtask

  task automatic test_contention();
    logic [NR-1:0] seen;
    int            gap;
`ifdef PLAY_PRIORITY_EN
    int            exp_idx[4] = '{0, 0, 0, 0};
`else
    int            exp_idx[4] = '{0, 2, 0, 2};
`endif
    do_reset();
    req = 4'b0101;
    for (int k = 0; k < 4; k++) begin
      wait_any_ack(seen, gap);
      n_total++; if (seen !== 4'(1 << exp_idx[k]))
        $display("FAIL cont_order k%0d got %b exp %b", k, seen, 4'(1 << exp_idx[k])); else n_pass++;
      n_total++; if (gap !== ((k == 0) ? 3 : 4))
        $display("FAIL cont_gap k%0d got %0d exp %0d", k, gap, (k == 0) ? 3 : 4); else n_pass++;
    end
    req = '0;
    tick();
    tick();
  endtask

  task automatic test_fairness();
    logic [NR-1:0] seen;
    int            gap;
`ifdef PLAY_PRIORITY_EN
    int            exp_idx[8] = '{0, 0, 0, 0, 0, 0, 0, 0};
`else
    int            exp_idx[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
`endif
    do_reset();
    req = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      wait_any_ack(seen, gap);
      n_total++; if (seen !== 4'(1 << exp_idx[k]))
        $display("FAIL fair_order k%0d got %b exp %b", k, seen, 4'(1 << exp_idx[k])); else n_pass++;
    end
    req = '0;
    tick();
    tick();
  endtask

  task automatic test_reset_mid_access();
    logic [NR-1:0] seen;
    int            gap;
    req = 4'b0010;
    tick();
    n_total++; if (mem_ce !== 1'b1) $display("FAIL mid_ce_before got %b exp 1", mem_ce); else n_pass++;
    i_rst = 1'b1;
    #1;
    n_total++; if (mem_ce !== 1'b0) $display("FAIL mid_ce_async got %b exp 0", mem_ce); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL mid_busy got %b exp 0", busy); else n_pass++;
    n_total++; if (rdata !== 16'h0) $display("FAIL mid_rdata got %h exp 0000", rdata); else n_pass++;
    req = 4'b1111;
    tick();
    n_total++; if (ack !== 4'b0000) $display("FAIL mid_no_ack got %b exp 0000", ack); else n_pass++;
    i_rst = 1'b0;
    wait_any_ack(seen, gap);
    n_total++; if (seen !== 4'b0001) $display("FAIL mid_next_win got %b exp 0001", seen); else n_pass++;
    n_total++; if (gap !== 3) $display("FAIL mid_latency got %0d exp 3", gap); else n_pass++;
    req = '0;
    tick();
    tick();
  endtask

`ifdef PLAY_PRIORITY_EN
  task automatic test_play_priority();
    logic [NR-1:0] seen;
    int            gap;
    int            exp_idx[6] = '{0, 0, 0, 1, 2, 3};
    do_reset();
    req = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      wait_any_ack(seen, gap);
      n_total++; if (seen !== 4'(1 << exp_idx[k]))
        $display("FAIL prio_order k%0d got %b exp %b", k, seen, 4'(1 << exp_idx[k])); else n_pass++;
      if (k == 2) req[0] = 1'b0;
    end
    req = '0;
    tick();
    tick();
  endtask
`endif

  initial begin
    n_pass  = 0;
    n_total = 0;
    i_rst   = 1'b1;
    test_reset();
    test_single_read();
    test_single_write();
    test_contention();
    test_fairness();
    test_reset_mid_access();
`ifdef PLAY_PRIORITY_EN
    test_play_priority();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
